// File: rtl/fp_pkg.sv
// Shared floating-point types: formats, rounding modes, operations, status flags,
// dispatch FSM states and per-format canonical NaN.
package fp_pkg;

  typedef enum logic [1:0] {FP32, FP64, FP16, FP16ALT} fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } float_op_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} dispatch_state_e;

  localparam int unsigned MaxFpWidth = 64;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      default: return 16;
    endcase
  endfunction

  // Right-aligned in a MaxFpWidth word; callers truncate to their format width.
  function automatic logic [MaxFpWidth-1:0] canonical_nan(fp_format_e fmt);
    case (fmt)
      FP32:    return 64'h0000_0000_7FC0_0000;
      FP64:    return 64'h7FF8_0000_0000_0000;
      FP16:    return 64'h0000_0000_0000_7E00;
      default: return 64'h0000_0000_0000_7FC0;
    endcase
  endfunction

endpackage

// File: rtl/fp_dispatch_wdog.sv
// Wait-state watchdog: start arms and zeroes the counter, clear disarms it;
// expired flags the final permitted cycle so a same-cycle FPU result can still win.
module fp_dispatch_wdog #(
  parameter int unsigned Limit = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q;
  logic            run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (clear) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = run_q && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/fp_dispatch.sv
// Single-outstanding dispatcher between a core FP request port and an FPU.
// Define FP_DISPATCH_TIMEOUT_EN to add a watchdog that answers a stalled FPU with a NaN error.
module fp_dispatch
  import fp_pkg::*;
#(
  parameter fp_format_e   FP_FORMAT      = FP32,
  parameter int unsigned  TAG_WIDTH      = 4,
  parameter int unsigned  TIMEOUT_CYCLES = 64,
  localparam int unsigned FP_WIDTH       = fp_width(FP_FORMAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FP_WIDTH-1:0]  req_a_i,
  input  logic [FP_WIDTH-1:0]  req_b_i,
  input  logic [FP_WIDTH-1:0]  req_c_i,
  input  roundmode_e           req_rnd_i,
  input  float_op_e            req_op_i,
  input  logic [1:0]           req_op_modify_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 fpu_start_o,
  input  logic                 fpu_ready_i,
  output logic [FP_WIDTH-1:0]  fpu_a_o,
  output logic [FP_WIDTH-1:0]  fpu_b_o,
  output logic [FP_WIDTH-1:0]  fpu_c_o,
  output roundmode_e           fpu_rnd_o,
  output float_op_e            fpu_op_o,
  output logic [1:0]           fpu_op_modify_o,
  input  logic [FP_WIDTH-1:0]  fpu_result_i,
  input  logic                 fpu_valid_i,
  input  status_t              fpu_flags_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [FP_WIDTH-1:0]  rsp_result_o,
  output status_t              rsp_flags_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic                 rsp_err_o,
  output status_t              fflags_o,
  input  logic                 fflags_clr_i
);

  dispatch_state_e      state_q;
  logic [FP_WIDTH-1:0]  a_q, b_q, c_q, result_q;
  roundmode_e           rnd_q;
  float_op_e            op_q;
  logic [1:0]           mod_q;
  logic [TAG_WIDTH-1:0] tag_q;
  status_t              flags_q, fflags_q;

  logic                 cap_en;
  logic [FP_WIDTH-1:0]  cap_result;
  status_t              cap_flags;

`ifdef FP_DISPATCH_TIMEOUT_EN
  localparam logic [FP_WIDTH-1:0] NanVal = FP_WIDTH'(canonical_nan(FP_FORMAT));

  logic wdog_expired;
  logic cap_err;
  logic err_q;

  fp_dispatch_wdog #(
    .Limit(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .start  (state_q == StIssue && fpu_ready_i),
    .clear  (cap_en),
    .expired(wdog_expired)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // A real FPU result takes priority over the watchdog in the limit cycle.
  always_comb begin
    cap_en     = 1'b0;
    cap_result = fpu_result_i;
    cap_flags  = fpu_flags_i;
`ifdef FP_DISPATCH_TIMEOUT_EN
    cap_err    = 1'b0;
`endif
    if (state_q == StWait) begin
      if (fpu_valid_i) begin
        cap_en = 1'b1;
`ifdef FP_DISPATCH_TIMEOUT_EN
      end else if (wdog_expired) begin
        cap_en     = 1'b1;
        cap_result = NanVal;
        cap_flags  = '{nv: 1'b1, default: 1'b0};
        cap_err    = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      rnd_q    <= RNE;
      op_q     <= FMADD;
      mod_q    <= '0;
      tag_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      fflags_q <= '0;
`ifdef FP_DISPATCH_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      // Clear drops the old accrued flags but never the flags captured this cycle.
      if (cap_en) begin
        fflags_q <= (fflags_clr_i ? '0 : fflags_q) | cap_flags;
      end else if (fflags_clr_i) begin
        fflags_q <= '0;
      end
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            a_q     <= req_a_i;
            b_q     <= req_b_i;
            c_q     <= req_c_i;
            rnd_q   <= req_rnd_i;
            op_q    <= req_op_i;
            mod_q   <= req_op_modify_i;
            tag_q   <= req_tag_i;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (fpu_ready_i) state_q <= StWait;
        end
        StWait: begin
          if (cap_en) begin
            result_q <= cap_result;
            flags_q  <= cap_flags;
`ifdef FP_DISPATCH_TIMEOUT_EN
            err_q    <= cap_err;
`endif
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o     = (state_q == StIdle);
  assign fpu_start_o     = (state_q == StIssue) && fpu_ready_i;
  assign fpu_a_o         = a_q;
  assign fpu_b_o         = b_q;
  assign fpu_c_o         = c_q;
  assign fpu_rnd_o       = rnd_q;
  assign fpu_op_o        = op_q;
  assign fpu_op_modify_o = mod_q;
  assign rsp_valid_o     = (state_q == StResp);
  assign rsp_result_o    = result_q;
  assign rsp_flags_o     = flags_q;
  assign rsp_tag_o       = tag_q;
  assign fflags_o        = fflags_q;
`ifdef FP_DISPATCH_TIMEOUT_EN
  assign rsp_err_o       = err_q;
`else
  assign rsp_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fp_dispatch.sv
// Self-checking bench for fp_dispatch; the watchdog scenario is built only when
// FP_DISPATCH_TIMEOUT_EN is defined.
module tb_fp_dispatch;
  import fp_pkg::*;

  localparam status_t FlNx = 5'b00001;
  localparam status_t FlOf = 5'b00100;
  localparam status_t FlDz = 5'b01000;
  localparam status_t FlNv = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_a = '0, req_b = '0, req_c = '0;
  roundmode_e  req_rnd = RNE;
  float_op_e   req_op = FMADD;
  logic [1:0]  req_mod = '0;
  logic [3:0]  req_tag = '0;
  logic        fpu_start, fpu_ready = 1'b0;
  logic [31:0] fpu_a, fpu_b, fpu_c;
  roundmode_e  fpu_rnd;
  float_op_e   fpu_op;
  logic [1:0]  fpu_mod;
  logic [31:0] fpu_result = '0;
  logic        fpu_valid = 1'b0;
  status_t     fpu_flags = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  status_t     rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  status_t     fflags;
  logic        fflags_clr = 1'b0;

  int      checks = 0;
  int      errors = 0;
  status_t exp_fflags = '0;

  always #5 clk = ~clk;

  fp_dispatch dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
    .req_rnd_i(req_rnd), .req_op_i(req_op), .req_op_modify_i(req_mod), .req_tag_i(req_tag),
    .fpu_start_o(fpu_start), .fpu_ready_i(fpu_ready),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_c_o(fpu_c),
    .fpu_rnd_o(fpu_rnd), .fpu_op_o(fpu_op), .fpu_op_modify_o(fpu_mod),
    .fpu_result_i(fpu_result), .fpu_valid_i(fpu_valid), .fpu_flags_i(fpu_flags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .rsp_tag_o(rsp_tag),
    .rsp_err_o(rsp_err), .fflags_o(fflags), .fflags_clr_i(fflags_clr)
  );

  // Plays core and FPU for one transaction and reports what it observed; n_bad counts
  // cycles where handshake outputs or held data departed from the protocol.
  task automatic run_txn(
    input logic [31:0] a, b, c, input roundmode_e rnd, input float_op_e op,
    input logic [1:0] md, input logic [3:0] tag,
    input int issue_dly, fpu_dly, rsp_dly,
    input logic [31:0] res, input status_t flg, input bit clr_at_cap, extra_req,
    output int n_start, n_bad, output logic [31:0] got_res, output status_t got_flags,
    output logic [3:0] got_tag, output logic got_err, ready_after);
    n_start = 0;
    n_bad   = 0;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_c = c;
    req_rnd = rnd; req_op = op; req_mod = md; req_tag = tag;
    #1;
    if (req_ready !== 1'b1) n_bad++;
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_c = $urandom;
    req_rnd = RTZ; req_op = SQRT; req_mod = ~md; req_tag = ~tag;
    for (int i = 0; i <= issue_dly; i++) begin
      fpu_ready = (i == issue_dly);
      #1;
      if (fpu_start === 1'b1) n_start++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || fpu_a !== a || fpu_b !== b ||
          fpu_c !== c || fpu_rnd !== rnd || fpu_op !== op || fpu_mod !== md) n_bad++;
      @(negedge clk);
    end
    fpu_ready = 1'b0;
    for (int k = 1; k <= fpu_dly; k++) begin
      fpu_valid  = (k == fpu_dly);
      fpu_result = (k == fpu_dly) ? res : $urandom;
      fpu_flags  = (k == fpu_dly) ? flg : status_t'(5'($urandom));
      fflags_clr = clr_at_cap && (k == fpu_dly);
      #1;
      if (fpu_start === 1'b1) n_start++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || fpu_a !== a || fpu_op !== op) n_bad++;
      @(negedge clk);
    end
    fpu_valid = 1'b0; fflags_clr = 1'b0;
    fpu_result = $urandom; fpu_flags = status_t'(5'($urandom));
    #1;
    got_res = rsp_result; got_flags = rsp_flags; got_tag = rsp_tag; got_err = rsp_err;
    for (int j = 0; j <= rsp_dly; j++) begin
      rsp_ready = (j == rsp_dly);
      req_valid = extra_req;
      #1;
      if (fpu_start === 1'b1) n_start++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== got_res ||
          rsp_flags !== got_flags || rsp_tag !== got_tag || rsp_err !== got_err) n_bad++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    #1;
    ready_after = req_ready && !rsp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fpu_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || fpu_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b start=%b valid=%b err=%b, need 1 0 0 0",
               req_ready, fpu_start, rsp_valid, rsp_err);
    end
    checks++;
    if (fpu_a !== 0 || fpu_b !== 0 || fpu_c !== 0 || rsp_result !== 0 || rsp_tag !== 0 ||
        rsp_flags !== 0 || fflags !== 0 || fpu_mod !== 0) begin
      errors++;
      $display("FAIL reset_data: a=%h b=%h c=%h res=%h tag=%h fl=%b ff=%b, need all 0",
               fpu_a, fpu_b, fpu_c, rsp_result, rsp_tag, rsp_flags, fflags);
    end
    @(negedge clk);
    fpu_ready = 1'b0;
    rst_n = 1'b1;
    exp_fflags = '0;
  endtask

  task automatic test_fadd();
    int n_start, n_bad; logic [31:0] r; status_t f; logic [3:0] t; logic e, ra;
    run_txn(32'h3F80_0000, 32'h4000_0000, 32'h0, RNE, ADD, 2'b00, 4'hA, 0, 3, 0,
            32'h4040_0000, '0, 1'b0, 1'b0, n_start, n_bad, r, f, t, e, ra);
    checks++;
    if (r !== 32'h4040_0000) begin
      errors++; $display("FAIL fadd_result: got %h need 40400000", r);
    end
    checks++;
    if (t !== 4'hA || e !== 1'b0) begin
      errors++; $display("FAIL fadd_tag_err: got tag %h err %b need a 0", t, e);
    end
    checks++;
    if (n_start != 1 || n_bad != 0 || ra !== 1'b1) begin
      errors++;
      $display("FAIL fadd_protocol: starts %0d bad %0d idle %b need 1 0 1", n_start, n_bad, ra);
    end
  endtask

  task automatic test_issue_stall();
    int n_start, n_bad; logic [31:0] r, a, res; status_t f; logic [3:0] t; logic e, ra;
    a = $urandom; res = $urandom;
    run_txn(a, ~a, a ^ 32'h5A5A_5A5A, RUP, MUL, 2'b01, 4'h3, 5, 2, 0, res, '0, 1'b0, 1'b0,
            n_start, n_bad, r, f, t, e, ra);
    checks++;
    if (n_start != 1) begin
      errors++; $display("FAIL stall_start_pulses: got %0d need 1", n_start);
    end
    checks++;
    if (n_bad != 0 || r !== res || t !== 4'h3) begin
      errors++;
      $display("FAIL stall_hold: bad %0d res %h tag %h need 0 %h 3", n_bad, r, t, res);
    end
  endtask

  task automatic test_rsp_backpressure();
    int n_start, n_bad; logic [31:0] r, res; status_t f; logic [3:0] t; logic e, ra;
    res = $urandom;
    run_txn($urandom, $urandom, $urandom, RDN, DIV, 2'b10, 4'hC, 1, 4, 4, res, '0, 1'b0, 1'b1,
            n_start, n_bad, r, f, t, e, ra);
    checks++;
    if (n_bad != 0 || r !== res || t !== 4'hC) begin
      errors++;
      $display("FAIL rsp_hold: bad %0d res %h tag %h need 0 %h c", n_bad, r, t, res);
    end
    checks++;
    if (ra !== 1'b1) begin
      errors++; $display("FAIL rsp_no_accept: idle-after %b need 1", ra);
    end
  endtask

  task automatic test_fflags();
    int n_start, n_bad; logic [31:0] r; status_t f; logic [3:0] t; logic e, ra;
    @(negedge clk);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    #1;
    exp_fflags = '0;
    checks++;
    if (fflags !== '0) begin
      errors++; $display("FAIL fflags_clear: got %b need 00000", fflags);
    end
    run_txn($urandom, $urandom, 0, RNE, ADD, 0, 4'h1, 0, 1, 0, $urandom, FlNx, 1'b0, 1'b0,
            n_start, n_bad, r, f, t, e, ra);
    run_txn($urandom, $urandom, 0, RNE, MUL, 0, 4'h2, 0, 2, 1, $urandom, FlOf, 1'b0, 1'b0,
            n_start, n_bad, r, f, t, e, ra);
    checks++;
    if (fflags !== status_t'(FlOf | FlNx) || f !== FlOf) begin
      errors++; $display("FAIL fflags_accrue: got %b (rsp %b) need 00101", fflags, f);
    end
    run_txn($urandom, $urandom, 0, RNE, DIV, 0, 4'h3, 0, 2, 0, $urandom, FlDz, 1'b1, 1'b0,
            n_start, n_bad, r, f, t, e, ra);
    exp_fflags = FlDz;
    checks++;
    if (fflags !== FlDz) begin
      errors++; $display("FAIL fflags_clr_capture: got %b need 01000", fflags);
    end
  endtask

  task automatic test_random();
    int n_start, n_bad; logic [31:0] r, res; status_t f, flg; logic [3:0] t, tag; logic e, ra;
    bit clr;
    for (int n = 0; n < 24; n++) begin
      res = $urandom; flg = status_t'(5'($urandom)); tag = 4'($urandom); clr = $urandom_range(0, 3) == 0;
      run_txn($urandom, $urandom, $urandom, roundmode_e'($urandom_range(0, 4)),
              float_op_e'($urandom_range(0, 14)), 2'($urandom), tag,
              $urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 3),
              res, flg, clr, 1'($urandom), n_start, n_bad, r, f, t, e, ra);
      exp_fflags = clr ? flg : status_t'(exp_fflags | flg);
      checks++;
      if (r !== res || f !== flg || t !== tag || e !== 1'b0) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: res %h fl %b tag %h err %b need %h %b %h 0",
                 n, r, f, t, e, res, flg, tag);
      end
      checks++;
      if (n_start != 1 || n_bad != 0 || ra !== 1'b1 || fflags !== exp_fflags) begin
        errors++;
        $display("FAIL rand_proto[%0d]: starts %0d bad %0d idle %b ff %b need 1 0 1 %b",
                 n, n_start, n_bad, ra, fflags, exp_fflags);
      end
    end
  endtask

`ifdef FP_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int waits, n_start, n_bad, late_bad; logic [31:0] r, res; status_t f; logic [3:0] t;
    logic e, ra;
    @(negedge clk);
    req_valid = 1'b1; req_a = $urandom; req_tag = 4'h7; req_op = ADD;
    @(negedge clk);
    req_valid = 1'b0; fpu_ready = 1'b1;
    @(negedge clk);
    fpu_ready = 1'b0;
    waits = 0;
    #1;
    while (rsp_valid !== 1'b1 && waits < 200) begin
      waits++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (waits != 64) begin
      errors++; $display("FAIL timeout_cycles: waited %0d need 64", waits);
    end
    checks++;
    if (rsp_result !== 32'h7FC0_0000 || rsp_flags !== FlNv || rsp_err !== 1'b1 || rsp_tag !== 4'h7) begin
      errors++;
      $display("FAIL timeout_rsp: res %h fl %b err %b tag %h need 7fc00000 10000 1 7",
               rsp_result, rsp_flags, rsp_err, rsp_tag);
    end
    exp_fflags = status_t'(exp_fflags | FlNv);
    late_bad = 0;
    fpu_valid = 1'b1; fpu_result = 32'h1234_5678; fpu_flags = FlOf;
    for (int i = 0; i < 4; i++) begin
      rsp_ready = (i == 1);
      @(negedge clk);
      #1;
      if ((i == 0 && rsp_result !== 32'h7FC0_0000) || (i > 0 && (rsp_valid !== 1'b0 || req_ready !== 1'b1)))
        late_bad++;
    end
    fpu_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (late_bad != 0 || fflags !== exp_fflags) begin
      errors++; $display("FAIL timeout_late_valid: bad %0d ff %b need 0 %b", late_bad, fflags, exp_fflags);
    end
    res = $urandom;
    run_txn($urandom, $urandom, 0, RNE, ADD, 0, 4'h9, 0, 64, 0, res, FlNx, 1'b0, 1'b0,
            n_start, n_bad, r, f, t, e, ra);
    exp_fflags = status_t'(exp_fflags | FlNx);
    checks++;
    if (r !== res || e !== 1'b0 || f !== FlNx || n_bad != 0) begin
      errors++;
      $display("FAIL timeout_limit_valid_wins: res %h err %b fl %b bad %0d need %h 0 00001 0",
               r, e, f, n_bad, res);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h1; req_tag = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; fpu_ready = 1'b1;
    @(negedge clk);
    fpu_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || fpu_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        fpu_a !== 0 || fpu_b !== 0 || rsp_result !== 0 || rsp_tag !== 0 || fflags !== 0) begin
      errors++;
      $display("FAIL midreset_outputs: ready %b start %b valid %b a %h res %h ff %b need reset values",
               req_ready, fpu_start, rsp_valid, fpu_a, rsp_result, fflags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_fflags = '0;
    fpu_valid = 1'b1; fpu_result = 32'hCAFE_F00D; fpu_flags = FlOf;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fpu_valid = 1'b0;
      #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || fflags !== exp_fflags) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset_no_response: %0d bad cycles, need 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_issue_stall();
    test_rsp_backpressure();
    test_fflags();
    test_random();
`ifdef FP_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_dispatch.md
FP_DISPATCH -- requirements
Module: fp_dispatch

Interface
REQ-001 SHALL have parameter FP_FORMAT, default FP32: operand format, with FP_WIDTH = fp_width(FP_FORMAT).
REQ-002 SHALL have parameter TAG_WIDTH, default 4: width of the request/response tag.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles spent in WAIT.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have core request ports:
- req_valid_i, input, 1 bit.
- req_ready_o, output, 1 bit.
- req_a_i, req_b_i, req_c_i, input, FP_WIDTH each: operands.
- req_rnd_i, input, roundmode_e.
- req_op_i, input, float_op_e.
- req_op_modify_i, input, 2 bits.
- req_tag_i, input, TAG_WIDTH.
REQ-007 SHALL have FPU issue ports:
- fpu_start_o, output, 1 bit.
- fpu_ready_i, input, 1 bit.
- fpu_a_o, fpu_b_o, fpu_c_o, output, FP_WIDTH each.
- fpu_rnd_o, output, roundmode_e.
- fpu_op_o, output, float_op_e.
- fpu_op_modify_o, output, 2 bits.
REQ-008 SHALL have FPU return ports: fpu_result_i, input, FP_WIDTH; fpu_valid_i, input, 1 bit; fpu_flags_i, input, status_t.
REQ-009 SHALL have core response ports:
- rsp_valid_o, output, 1 bit.
- rsp_ready_i, input, 1 bit.
- rsp_result_o, output, FP_WIDTH.
- rsp_flags_o, output, status_t.
- rsp_tag_o, output, TAG_WIDTH.
- rsp_err_o, output, 1 bit.
REQ-010 SHALL have accrued-flag ports: fflags_o, output, status_t (sticky exception flags); fflags_clr_i, input, 1 bit.

Function
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one operation outstanding at a time.
REQ-012 IDLE SHALL drive req_ready_o=1 and, on req_valid_i=1, register every req_* field and move to ISSUE.
- req_ready_o SHALL be 0 in all other states.
REQ-013 ISSUE SHALL drive fpu_start_o = fpu_ready_i.
- fpu_*_o SHALL equal the registered request fields whenever the FSM is not in IDLE.
- The FSM SHALL move to WAIT in the cycle fpu_ready_i=1, so start is a single-cycle pulse.
REQ-014 WAIT SHALL, on fpu_valid_i=1, capture fpu_result_i and fpu_flags_i and move to RESP.
- fpu_valid_i SHALL be ignored in every state other than WAIT.
REQ-015 RESP SHALL hold rsp_valid_o=1 with stable rsp_result_o, rsp_flags_o, rsp_tag_o and rsp_err_o until rsp_ready_i=1, then return to IDLE.
REQ-016 Minimum latency SHALL be: accept at cycle N, start at N+1, rsp_valid_o at the cycle after fpu_valid_i.
- A new request SHALL NOT be accepted in the cycle rsp_ready_i completes the handshake.
REQ-017 fflags_o SHALL OR in the captured response flags on entry to RESP.
- fflags_clr_i=1 SHALL zero fflags_o.
- When clear and capture occur in the same cycle, the result SHALL be the new flags only.

Reset
REQ-018 While rst_i=0, the block SHALL hold FSM=IDLE and every captured register at zero.
REQ-019 Output values in reset SHALL be: req_ready_o=1; fpu_start_o, rsp_valid_o and rsp_err_o =0; all data outputs and fflags_o =0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation with no response.
- A late fpu_valid_i after release SHALL be ignored.

Configuration
REQ-021 With FP_DISPATCH_TIMEOUT_EN defined, a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL:
- clear on entry to WAIT and increment each WAIT cycle;
- on reaching TIMEOUT_CYCLES with fpu_valid_i=0, force RESP with canonical quiet NaN, flags NV only, rsp_err_o=1.
- fpu_valid_i in the limit cycle SHALL win over the timeout.
REQ-022 Without FP_DISPATCH_TIMEOUT_EN, no counter SHALL exist, rsp_err_o SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-023 fp_pkg SHALL hold dispatch_state_e and a canonical-NaN function keyed by fp_format_e; status_t, roundmode_e and float_op_e come from fp_pkg.
REQ-024 The watchdog SHALL be the sub-module fp_dispatch_wdog (inputs start/clear, output expired), instantiated only under the macro.

Verification
REQ-025 Bench SHALL cover: FADD a=0x3F800000 b=0x40000000, FPU returns 0x40400000 after 3 cycles -> rsp_result_o=0x40400000, tag echoed, rsp_err_o=0.
REQ-026 Bench SHALL cover: fpu_ready_i held 0 for 5 cycles -> req_ready_o=0 throughout, exactly one fpu_start_o pulse, operands stable.
REQ-027 Bench SHALL cover: rsp_ready_i low for 4 cycles -> rsp_valid_o and data held, and a second req_valid_i is not accepted.
REQ-028 Bench SHALL cover: responses with flags NX then OF -> fflags_o=OF|NX; fflags_clr_i in the same cycle as a DZ capture -> fflags_o=DZ.
REQ-029 Bench SHALL cover, with the macro defined: no fpu_valid_i for 64 cycles -> rsp_result_o=0x7FC00000, NV set, rsp_err_o=1; a later fpu_valid_i is ignored.
REQ-030 Bench SHALL cover: rst_i pulsed low during WAIT -> all outputs at reset values, and no response is produced.
